// File: rtl/tcsm_smtc.sv
// rtl/tcsm_smtc.sv - registered two's-complement <-> sign-magnitude LLR converter
// One output register stage; out_data/flags hold across idle cycles.
module tcsm_smtc #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         mode,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_sat,
  output logic         out_negz
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         sat_q, sat_d;
  logic         negz_q, negz_d;

  logic         sign;
  logic         mag_zero;
  logic [W-1:0] neg_x;
  logic [W-1:0] neg_m;
  logic [W-1:0] conv_data;
  logic         conv_sat;
  logic         conv_negz;

  always_comb begin
    sign      = in_data[W-1];
    mag_zero  = (in_data[W-2:0] == '0);
    neg_x     = ~in_data + {{(W-1){1'b0}}, 1'b1};
    neg_m     = ~{1'b0, in_data[W-2:0]} + {{(W-1){1'b0}}, 1'b1};
    conv_data = in_data;
    conv_sat  = 1'b0;
    conv_negz = 1'b0;
    if (sign) begin
      if (!mode) begin
        // -2^(W-1) has no SM magnitude; clamp to the most negative SM code
        if (mag_zero) begin
          conv_data = '1;
          conv_sat  = 1'b1;
        end else begin
          conv_data = {1'b1, neg_x[W-2:0]};
        end
      end else begin
        if (mag_zero) begin
          conv_data = '0;
          conv_negz = 1'b1;
        end else begin
          conv_data = neg_m;
        end
      end
    end
  end

  always_comb begin
    valid_d = in_valid;
    data_d  = data_q;
    sat_d   = sat_q;
    negz_d  = negz_q;
    if (in_valid) begin
      data_d = conv_data;
      sat_d  = conv_sat;
      negz_d = conv_negz;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      negz_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      negz_q  <= negz_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sat   = sat_q;
  assign out_negz  = negz_q;

endmodule

// File: tb/tb_tcsm_smtc.sv
// tb/tb_tcsm_smtc.sv - directed vector bench for tcsm_smtc (W=5 unit, W=8 chained round trip)
module tb_tcsm_smtc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       mode;
  logic [4:0] in_data;
  logic       out_valid;
  logic [4:0] out_data;
  logic       out_sat;
  logic       out_negz;

  logic       a_in_valid;
  logic [7:0] a_in_data;
  logic       a_valid, a_sat, a_negz;
  logic [7:0] a_data;
  logic       b_valid, b_sat, b_negz;
  logic [7:0] b_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcsm_smtc #(.W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .out_negz(out_negz)
  );

  tcsm_smtc #(.W(8)) u_a8 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .mode(1'b0), .in_data(a_in_data),
    .out_valid(a_valid), .out_data(a_data), .out_sat(a_sat), .out_negz(a_negz)
  );

  tcsm_smtc #(.W(8)) u_b8 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .mode(1'b1), .in_data(a_data),
    .out_valid(b_valid), .out_data(b_data), .out_sat(b_sat), .out_negz(b_negz)
  );

  typedef struct {
    logic       mode;
    logic [4:0] din;
    logic [4:0] dout;
    logic       sat;
    logic       negz;
  } vec_t;

  // Reference: {sat, negz, data[7:0]} computed via integer arithmetic
  function automatic logic [9:0] ref_conv(int w, logic m, int x);
    int half = 1 << (w - 1);
    int full = 1 << w;
    int ux   = x % full;
    int v;
    int mag;
    logic [9:0] r = '0;
    if (!m) begin
      v = (ux >= half) ? ux - full : ux;
      if (v == -half) begin
        r[9] = 1'b1;
        r[7:0] = 8'(full - 1);
      end else if (v < 0) r[7:0] = 8'(half - v);
      else r[7:0] = 8'(ux);
    end else begin
      mag = ux % half;
      if (ux >= half && mag == 0) r[8] = 1'b1;
      else begin
        v = (ux >= half) ? -mag : mag;
        r[7:0] = 8'((v + full) % full);
      end
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(logic v, logic m, logic [4:0] d);
    in_valid = v;
    mode     = m;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string name);
    check({name, " valid"}, 32'(out_valid), 0);
    check({name, " data"},  32'(out_data), 0);
    check({name, " sat"},   32'(out_sat), 0);
    check({name, " negz"},  32'(out_negz), 0);
  endtask

  vec_t vecs[8];
  logic [9:0] r;
  logic [4:0] mid;

  initial begin
    vecs[0] = '{1'b0, 5'b10001, 5'b11111, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 5'b11111, 5'b10001, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 5'b00110, 5'b00110, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 5'b10000, 5'b11111, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 5'b10001, 5'b11111, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'b11111, 5'b10001, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'b01010, 5'b01010, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 5'b10000, 5'b00000, 1'b0, 1'b1};

    a_in_valid = 1'b0;
    a_in_data  = '0;
    rst_n      = 1'b0;
    #1;
    apply(1'b1, 1'b0, 5'b10001);
    check_zero("reset1");
    apply(1'b1, 1'b0, 5'b10001);
    check_zero("reset2");
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 5'b10001);
    check("post reset valid", 32'(out_valid), 0);

    for (int i = 0; i < 8; i++) begin
      apply(1'b1, vecs[i].mode, vecs[i].din);
      check($sformatf("vec%0d valid", i), 32'(out_valid), 1);
      check($sformatf("vec%0d data", i),  32'(out_data), 32'(vecs[i].dout));
      check($sformatf("vec%0d sat", i),   32'(out_sat), 32'(vecs[i].sat));
      check($sformatf("vec%0d negz", i),  32'(out_negz), 32'(vecs[i].negz));
    end

    // idle cycles must hold data and flags while out_valid drops
    apply(1'b1, 1'b0, 5'b10011);
    check("gap word data", 32'(out_data), 32'h1d);
    apply(1'b0, 1'b1, 5'b10000);
    check("gap idle valid", 32'(out_valid), 0);
    check("gap idle data hold", 32'(out_data), 32'h1d);
    check("gap idle negz", 32'(out_negz), 0);
    apply(1'b1, 1'b0, 5'b10000);
    check("gap sat valid", 32'(out_valid), 1);
    apply(1'b0, 1'b0, 5'b00001);
    apply(1'b0, 1'b1, 5'b10000);
    check("gap sat hold", 32'(out_sat), 1);
    check("gap sat data hold", 32'(out_data), 32'h1f);
    apply(1'b1, 1'b1, 5'b10000);
    apply(1'b0, 1'b0, 5'b10000);
    check("gap negz hold", 32'(out_negz), 1);
    check("gap negz sat", 32'(out_sat), 0);
    check("gap negz valid", 32'(out_valid), 0);

    for (int i = 0; i < 32; i++) begin
      apply(1'b1, 1'(i & 1), 5'(i));
      r = ref_conv(5, 1'(i & 1), i);
      check($sformatf("stream%0d valid", i), 32'(out_valid), 1);
      check($sformatf("stream%0d data", i),  32'(out_data), 32'(r[4:0]));
      check($sformatf("stream%0d sat", i),   32'(out_sat), 32'(r[9]));
      check($sformatf("stream%0d negz", i),  32'(out_negz), 32'(r[8]));
    end

    for (int x = 0; x < 32; x++) begin
      if (x == 20) begin
        rst_n = 1'b0;
        apply(1'b1, 1'b0, 5'(x));
        check_zero("midsweep reset");
        rst_n = 1'b1;
      end
      if (x != 16) begin
        apply(1'b1, 1'b0, 5'(x));
        mid = out_data;
        apply(1'b1, 1'b1, mid);
        check($sformatf("rt5 tc%0d", x), 32'(out_data), 32'(x));
        apply(1'b1, 1'b1, 5'(x));
        mid = out_data;
        apply(1'b1, 1'b0, mid);
        check($sformatf("rt5 sm%0d", x), 32'(out_data), 32'(x));
      end
    end

    apply(1'b0, 1'b0, 5'b0);
    for (int x = 0; x <= 256; x++) begin
      a_in_valid = (x < 256);
      a_in_data  = 8'(x);
      @(posedge clk);
      #1;
      if (x == 128) check("rt8 sat", 32'(a_sat), 1);
      if (x >= 1) begin
        check($sformatf("rt8 valid%0d", x - 1), 32'(b_valid), 1);
        if (x - 1 != 128)
          check($sformatf("rt8 data%0d", x - 1), 32'(b_data), 32'(x - 1));
      end
    end
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rt8 drain valid", 32'(b_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
